stage_x_fetch: RTL

//  Instruction-fetch stage x of the rv64 ready-valid pipeline. It sits directly upstream of stage y (decode).

---
 rtl/rv64_pipe_pkg.sv | 35 +++
 rtl/stage_x_fetch_if.sv | 25 ++
 rtl/stage_x_pcgen.sv | 23 ++
 rtl/stage_x_fetch.sv | 77 +++++++
 4 files changed

// File: rtl/rv64_pipe_pkg.sv
// Shared definitions for the rv64 ready-valid pipeline: widths, reset PC,
// fetch state encoding and the {pc, inst} x->y bus layout.
package rv64_pipe_pkg;

  localparam int XLEN         = 64;
  localparam int INST_W       = 32;
  localparam int X_TO_Y_BUS_W = XLEN + INST_W;

  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_CANCEL
  } fetch_state_e;

  // pc occupies the MSBs so stage_y can slice it directly.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } x_to_y_bus_t;

  function automatic x_to_y_bus_t pack_x_to_y(input logic [XLEN-1:0]   pc,
                                              input logic [INST_W-1:0] inst);
    x_to_y_bus_t b;
    b.pc   = pc;
    b.inst = inst;
    return b;
  endfunction

  function automatic x_to_y_bus_t unpack_x_to_y(input logic [X_TO_Y_BUS_W-1:0] bus);
    return x_to_y_bus_t'(bus);
  endfunction

endpackage

// File: rtl/stage_x_fetch_if.sv
// Handshake bundle of the fetch stage: split imem req/addr_ok/data_ok port
// plus the valid/allow_in hand-off to decode.
interface stage_x_fetch_if;
  import rv64_pipe_pkg::*;

  logic                    imem_req;
  logic [XLEN-1:0]         imem_addr;
  logic                    imem_addr_ok;
  logic                    imem_data_ok;
  logic [INST_W-1:0]       imem_rdata;
  logic                    x_to_y_valid;
  logic [X_TO_Y_BUS_W-1:0] x_to_y_bus;
  logic                    y_allow_in;

  modport master (
    output imem_req, imem_addr, x_to_y_valid, x_to_y_bus,
    input  imem_addr_ok, imem_data_ok, imem_rdata, y_allow_in
  );

  modport slave (
    input  imem_req, imem_addr, x_to_y_valid, x_to_y_bus,
    output imem_addr_ok, imem_data_ok, imem_rdata, y_allow_in
  );

endinterface

// File: rtl/stage_x_pcgen.sv
// PC register of the fetch stage with its next-pc mux: redirect, +4, or hold.
module stage_x_pcgen #(
  parameter logic [rv64_pipe_pkg::XLEN-1:0] RESET_PC = rv64_pipe_pkg::RESET_PC
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           br_redirect,
  input  logic [rv64_pipe_pkg::XLEN-1:0] br_target,
  input  logic                           advance,
  output logic [rv64_pipe_pkg::XLEN-1:0] pc
);
  import rv64_pipe_pkg::*;

  // Redirect beats advance; +4 wraps naturally at 2^XLEN.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset)            pc <= RESET_PC;
    else if (br_redirect) pc <= br_target;
    else if (advance)     pc <= pc + XLEN'(4);
  end

endmodule

// File: rtl/stage_x_fetch.sv
// Instruction-fetch stage x: one outstanding imem fetch, one-entry output
// register towards decode, redirect flushes the buffer and cancels in-flight data.
module stage_x_fetch #(
  parameter logic [rv64_pipe_pkg::XLEN-1:0] RESET_PC = rv64_pipe_pkg::RESET_PC
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           br_redirect,
  input  logic [rv64_pipe_pkg::XLEN-1:0] br_target,
  stage_x_fetch_if.master                pipe
);
  import rv64_pipe_pkg::*;

  fetch_state_e      state;
  logic [XLEN-1:0]   pc;
  logic              x_valid;
  logic [XLEN-1:0]   x_pc;
  logic [INST_W-1:0] x_inst;
  logic              buf_free;
  logic              fill;

  // Buffer will be empty next cycle: either empty now or draining into y.
  assign buf_free = !x_valid || pipe.y_allow_in;

  // Only issue when the returning data is guaranteed a free buffer slot.
  assign pipe.imem_req  = !reset && (state == S_REQ) && buf_free && !br_redirect;
  assign pipe.imem_addr = pc;

  assign fill = (state == S_WAIT) && pipe.imem_data_ok && !br_redirect;

  stage_x_pcgen #(.RESET_PC(RESET_PC)) u_pcgen (
    .clk         (clk),
    .reset       (reset),
    .br_redirect (br_redirect),
    .br_target   (br_target),
    .advance     (fill),
    .pc          (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_REQ;
      x_valid <= 1'b0;
    end else if (br_redirect) begin
      x_valid <= 1'b0;
      // Data returning alongside the redirect retires the outstanding fetch,
      // so there is nothing left to cancel.
      case (state)
        S_WAIT, S_CANCEL: state <= pipe.imem_data_ok ? S_REQ : S_CANCEL;
        default:          state <= S_REQ;
      endcase
    end else begin
      if (fill)                               x_valid <= 1'b1;
      else if (x_valid && pipe.y_allow_in)    x_valid <= 1'b0;

      case (state)
        S_REQ:    if (pipe.imem_req && pipe.imem_addr_ok) state <= S_WAIT;
        S_WAIT:   if (pipe.imem_data_ok)                  state <= S_REQ;
        S_CANCEL: if (pipe.imem_data_ok)                  state <= S_REQ;
        default:                                          state <= S_REQ;
      endcase
    end
  end

  // NOTE: payload registers carry no reset; x_valid alone qualifies them,
  // so resetting the wide datapath would buy nothing.
  always_ff @(posedge clk) begin
    if (fill) begin
      x_pc   <= pc;
      x_inst <= pipe.imem_rdata;
    end
  end

  assign pipe.x_to_y_valid = x_valid;
  assign pipe.x_to_y_bus   = pack_x_to_y(x_pc, x_inst);

endmodule
